// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU between two requesters: port 0 (EX-stage
// pipeline) and port 1 (auxiliary unit: address generation / debug).
// Requests are arbitrated round-robin in IDLE. The winner's operands are
// registered, the shared ALU is driven from those registers for exactly one
// cycle (EXEC), and the captured result/overflow is then held on the winner's
// response channel (RESP) until that port accepts it.
//
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   reqN_valid / reqN_ready        request handshake for port N (N = 0, 1)
//   reqN_op, reqN_in_0, reqN_in_1  opcode and operands for port N
//   rspN_valid / rspN_ready        response handshake for port N
//   rspN_out, rspN_of              result and overflow flag for port N
//   alu_op, alu_in_0, alu_in_1     drive to the shared ALU
//   alu_out, alu_of                result from the shared ALU
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int              DATA_W = 32,
  parameter int              OP_W   = 4,
  parameter logic [OP_W-1:0] NOP_OP = '0
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_in_0,
  input  logic [DATA_W-1:0] req0_in_1,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_out,
  output logic              rsp0_of,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_in_0,
  input  logic [DATA_W-1:0] req1_in_1,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_out,
  output logic              rsp1_of,

  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_in_0,
  output logic [DATA_W-1:0] alu_in_1,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_of
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_next;

  // prio names the port that wins when both request; owner is the port whose
  // operation is currently in flight.
  logic prio, prio_next;
  logic owner, owner_next;

  logic              grant_valid;
  logic              grant;
  logic              accept;

  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] in0_q;
  logic [DATA_W-1:0] in1_q;
  logic [DATA_W-1:0] res_q;
  logic              of_q;

  // Control state register: FSM state, round-robin pointer and owner id.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      prio  <= 1'b0;
      owner <= 1'b0;
    end else begin
      state <= state_next;
      prio  <= prio_next;
      owner <= owner_next;
    end
  end

  // Next-state and output decode. Ready is combinational on the request
  // valids so a port can be accepted in the same cycle it raises valid. The
  // ALU sees operands only during EXEC so it idles on NOP otherwise, and the
  // response buses read zero except for the owner while it holds RESP.
  always_comb begin
    state_next  = state;
    prio_next   = prio;
    owner_next  = owner;
    grant_valid = 1'b0;
    grant       = 1'b0;
    accept      = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp0_out    = '0;
    rsp0_of     = 1'b0;
    rsp1_valid  = 1'b0;
    rsp1_out    = '0;
    rsp1_of     = 1'b0;
    alu_op      = NOP_OP;
    alu_in_0    = '0;
    alu_in_1    = '0;

    case (state)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          grant_valid = 1'b1;
          grant       = prio;
        end else if (req0_valid) begin
          grant_valid = 1'b1;
          grant       = 1'b0;
        end else if (req1_valid) begin
          grant_valid = 1'b1;
          grant       = 1'b1;
        end
        req0_ready = grant_valid && !grant;
        req1_ready = grant_valid && grant;
        if (grant_valid) begin
          accept     = 1'b1;
          owner_next = grant;
          prio_next  = ~grant;
          state_next = EXEC;
        end
      end

      EXEC: begin
        alu_op     = op_q;
        alu_in_0   = in0_q;
        alu_in_1   = in1_q;
        state_next = RESP;
      end

      RESP: begin
        if (!owner) begin
          rsp0_valid = 1'b1;
          rsp0_out   = res_q;
          rsp0_of    = of_q;
          if (rsp0_ready) begin
            state_next = IDLE;
          end
        end else begin
          rsp1_valid = 1'b1;
          rsp1_out   = res_q;
          rsp1_of    = of_q;
          if (rsp1_ready) begin
            state_next = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture on acceptance and result capture at the end of EXEC.
  // The result registers are not cleared after the handshake because the
  // response buses are already gated to zero outside RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= NOP_OP;
      in0_q <= '0;
      in1_q <= '0;
      res_q <= '0;
      of_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= grant ? req1_op   : req0_op;
        in0_q <= grant ? req1_in_0 : req0_in_0;
        in1_q <= grant ? req1_in_1 : req0_in_1;
      end
      if (state == EXEC) begin
        res_q <= alu_out;
        of_q  <= alu_of;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. A behavioural ALU is attached to the
// shared ALU port. A transaction-level reference model tracks the phase of the
// in-flight operation (idle / executing / responding), the favoured port and
// the expected result computed at acceptance time; every cycle all DUT
// outputs are compared against it at the falling edge. Directed scenarios are
// followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_AND  = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_ADDS = 4'd4;
  localparam logic [3:0] OP_ADDU = 4'd5;
  localparam logic [3:0] OP_SUBS = 4'd6;
  localparam logic [3:0] OP_SUBU = 4'd7;
  localparam logic [3:0] OP_SHRL = 4'd8;
  localparam logic [3:0] OP_SHLL = 4'd9;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;

  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [3:0]  req0_op    = '0;
  logic [31:0] req0_in_0  = '0;
  logic [31:0] req0_in_1  = '0;
  logic        rsp0_valid;
  logic        rsp0_ready = 1'b0;
  logic [31:0] rsp0_out;
  logic        rsp0_of;

  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [3:0]  req1_op    = '0;
  logic [31:0] req1_in_0  = '0;
  logic [31:0] req1_in_1  = '0;
  logic        rsp1_valid;
  logic        rsp1_ready = 1'b0;
  logic [31:0] rsp1_out;
  logic        rsp1_of;

  logic [3:0]  alu_op;
  logic [31:0] alu_in_0;
  logic [31:0] alu_in_1;
  logic [31:0] alu_out;
  logic        alu_of;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: phase 0 idle, 1 executing, 2 responding
  int          m_phase = 0;
  int          m_ptr   = 0;
  int          m_owner = 0;
  logic [3:0]  m_op    = '0;
  logic [31:0] m_a     = '0;
  logic [31:0] m_b     = '0;
  logic [31:0] m_res   = '0;
  logic        m_of    = 1'b0;
  bit          acc0    = 1'b0;
  bit          acc1    = 1'b0;

  always #5 clk = ~clk;

  alu_arbiter #(
    .DATA_W (32),
    .OP_W   (4),
    .NOP_OP (OP_NOP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_in_0  (req0_in_0),
    .req0_in_1  (req0_in_1),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_out   (rsp0_out),
    .rsp0_of    (rsp0_of),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_in_0  (req1_in_0),
    .req1_in_1  (req1_in_1),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_out   (rsp1_out),
    .rsp1_of    (rsp1_of),
    .alu_op     (alu_op),
    .alu_in_0   (alu_in_0),
    .alu_in_1   (alu_in_1),
    .alu_out    (alu_out),
    .alu_of     (alu_of)
  );

  // behavioural ALU: returns {overflow, result}
  function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic        o;
    r = '0;
    o = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_ADDS: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_ADDU: r = a + b;
      OP_SUBS: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
      OP_SUBU: r = a - b;
      OP_SHRL: r = a >> b[4:0];
      OP_SHLL: r = a << b[4:0];
      default: r = '0;
    endcase
    return {o, r};
  endfunction

  assign {alu_of, alu_out} = alu_ref(alu_op, alu_in_0, alu_in_1);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Drive one cycle of inputs just after the rising edge, then compare every
  // output against the model at the falling edge.
  task automatic applyStimulus(input logic v0, input logic [3:0] o0, input logic [31:0] a0,
                               input logic [31:0] b0, input logic v1, input logic [3:0] o1,
                               input logic [31:0] a1, input logic [31:0] b1,
                               input logic r0, input logic r1);
    bit gv;
    int g;
    req0_valid = v0; req0_op = o0; req0_in_0 = a0; req0_in_1 = b0;
    req1_valid = v1; req1_op = o1; req1_in_0 = a1; req1_in_1 = b1;
    rsp0_ready = r0; rsp1_ready = r1;
    #4;
    gv = (m_phase == 0) && (v0 || v1);
    g  = (v0 && v1) ? m_ptr : (v0 ? 0 : 1);
    checkOutput("req0_ready", 32'(req0_ready), 32'(gv && g == 0));
    checkOutput("req1_ready", 32'(req1_ready), 32'(gv && g == 1));
    checkOutput("alu_op",   32'(alu_op), (m_phase == 1) ? 32'(m_op) : 32'(OP_NOP));
    checkOutput("alu_in_0", alu_in_0, (m_phase == 1) ? m_a : 32'h0);
    checkOutput("alu_in_1", alu_in_1, (m_phase == 1) ? m_b : 32'h0);
    checkOutput("rsp0_valid", 32'(rsp0_valid), 32'(m_phase == 2 && m_owner == 0));
    checkOutput("rsp0_out", rsp0_out, (m_phase == 2 && m_owner == 0) ? m_res : 32'h0);
    checkOutput("rsp0_of", 32'(rsp0_of), (m_phase == 2 && m_owner == 0) ? 32'(m_of) : 32'h0);
    checkOutput("rsp1_valid", 32'(rsp1_valid), 32'(m_phase == 2 && m_owner == 1));
    checkOutput("rsp1_out", rsp1_out, (m_phase == 2 && m_owner == 1) ? m_res : 32'h0);
    checkOutput("rsp1_of", 32'(rsp1_of), (m_phase == 2 && m_owner == 1) ? 32'(m_of) : 32'h0);
  endtask

  task automatic applyIdle(input logic r0, input logic r1);
    applyStimulus(1'b0, OP_NOP, 32'h0, 32'h0, 1'b0, OP_NOP, 32'h0, 32'h0, r0, r1);
  endtask

  // Move the model across the rising edge using the inputs that were applied.
  task automatic advance();
    int g;
    acc0 = 1'b0;
    acc1 = 1'b0;
    @(posedge clk);
    case (m_phase)
      0: begin
        if (req0_valid || req1_valid) begin
          g = (req0_valid && req1_valid) ? m_ptr : (req0_valid ? 0 : 1);
          m_owner = g;
          m_ptr   = 1 - g;
          if (g == 0) begin
            m_op = req0_op; m_a = req0_in_0; m_b = req0_in_1; acc0 = 1'b1;
          end else begin
            m_op = req1_op; m_a = req1_in_0; m_b = req1_in_1; acc1 = 1'b1;
          end
          {m_of, m_res} = alu_ref(m_op, m_a, m_b);
          m_phase = 1;
        end
      end
      1: m_phase = 2;
      default: begin
        if ((m_owner == 0 && rsp0_ready) || (m_owner == 1 && rsp1_ready)) m_phase = 0;
      end
    endcase
    #1;
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic doReset();
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    m_phase = 0; m_ptr = 0; m_owner = 0;
    checkOutput("rst_req0_ready", 32'(req0_ready), 32'h0);
    checkOutput("rst_req1_ready", 32'(req1_ready), 32'h0);
    checkOutput("rst_rsp0_valid", 32'(rsp0_valid), 32'h0);
    checkOutput("rst_rsp1_valid", 32'(rsp1_valid), 32'h0);
    checkOutput("rst_rsp0_out",   rsp0_out, 32'h0);
    checkOutput("rst_rsp1_out",   rsp1_out, 32'h0);
    checkOutput("rst_rsp0_of",    32'(rsp0_of), 32'h0);
    checkOutput("rst_rsp1_of",    32'(rsp1_of), 32'h0);
    checkOutput("rst_alu_op",     32'(alu_op), 32'(OP_NOP));
    checkOutput("rst_alu_in_0",   alu_in_0, 32'h0);
    checkOutput("rst_alu_in_1",   alu_in_1, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic        p0v, p1v;
  logic [3:0]  p0o, p1o;
  logic [31:0] p0a, p0b, p1a, p1b;

  initial begin
    #2;
    doReset();

    // port 0 AND, then port 1 accepted right after port 0's handshake
    applyStimulus(1'b1, OP_AND, 32'h0f, 32'hf0, 1'b0, OP_NOP, 32'h0, 32'h0, 1'b1, 1'b0);
    checkOutput("and_req0_ready", 32'(req0_ready), 32'h1);
    advance();
    applyIdle(1'b1, 1'b0);
    checkOutput("and_alu_op", 32'(alu_op), 32'(OP_AND));
    advance();
    applyIdle(1'b1, 1'b0);
    checkOutput("and_rsp0_valid", 32'(rsp0_valid), 32'h1);
    checkOutput("and_rsp0_out", rsp0_out, 32'h0);
    checkOutput("and_rsp0_of", 32'(rsp0_of), 32'h0);
    advance();

    // port 1 signed add with overflow
    applyStimulus(1'b0, OP_NOP, 32'h0, 32'h0, 1'b1, OP_ADDS, 32'h7fffffff, 32'h7fffffff,
                  1'b0, 1'b1);
    checkOutput("adds_req1_ready", 32'(req1_ready), 32'h1);
    advance();
    applyIdle(1'b0, 1'b1);
    advance();
    applyIdle(1'b0, 1'b1);
    checkOutput("adds_rsp1_out", rsp1_out, 32'hfffffffe);
    checkOutput("adds_rsp1_of", 32'(rsp1_of), 32'h1);
    checkOutput("adds_rsp0_valid", 32'(rsp0_valid), 32'h0);
    advance();
    applyIdle(1'b1, 1'b1);
    advance();

    // simultaneous requests alternate starting with port 0
    doReset();
    applyStimulus(1'b1, OP_XOR, 32'h0f, 32'hf0, 1'b1, OP_SHLL, 32'h0f0f0f0f, 32'h4, 1'b1, 1'b1);
    checkOutput("sim_req0_ready", 32'(req0_ready), 32'h1);
    checkOutput("sim_req1_wait", 32'(req1_ready), 32'h0);
    advance();
    applyStimulus(1'b0, OP_NOP, 32'h0, 32'h0, 1'b1, OP_SHLL, 32'h0f0f0f0f, 32'h4, 1'b1, 1'b1);
    advance();
    applyStimulus(1'b0, OP_NOP, 32'h0, 32'h0, 1'b1, OP_SHLL, 32'h0f0f0f0f, 32'h4, 1'b1, 1'b1);
    checkOutput("sim_rsp0_out", rsp0_out, 32'h000000ff);
    advance();
    applyStimulus(1'b0, OP_NOP, 32'h0, 32'h0, 1'b1, OP_SHLL, 32'h0f0f0f0f, 32'h4, 1'b1, 1'b1);
    checkOutput("sim_req1_ready", 32'(req1_ready), 32'h1);
    advance();
    applyIdle(1'b1, 1'b1);
    advance();
    applyIdle(1'b1, 1'b1);
    checkOutput("sim_rsp1_out", rsp1_out, 32'hf0f0f0f0);
    advance();
    applyStimulus(1'b1, OP_AND, 32'h3, 32'h1, 1'b1, OP_OR, 32'h4, 32'h8, 1'b1, 1'b1);
    checkOutput("sim_third_req0", 32'(req0_ready), 32'h1);
    advance();
    repeat (3) begin applyIdle(1'b1, 1'b1); advance(); end

    // backpressure on port 0 while port 1 waits
    applyStimulus(1'b1, OP_SUBS, 32'h5, 32'h2, 1'b0, OP_NOP, 32'h0, 32'h0, 1'b0, 1'b0);
    advance();
    applyStimulus(1'b0, OP_NOP, 32'h0, 32'h0, 1'b1, OP_OR, 32'h1, 32'h2, 1'b0, 1'b0);
    advance();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, OP_NOP, 32'h0, 32'h0, 1'b1, OP_OR, 32'h1, 32'h2, 1'b0, 1'b0);
      checkOutput("bp_rsp0_valid", 32'(rsp0_valid), 32'h1);
      checkOutput("bp_rsp0_out", rsp0_out, 32'h3);
      checkOutput("bp_req1_stall", 32'(req1_ready), 32'h0);
      advance();
    end
    applyStimulus(1'b0, OP_NOP, 32'h0, 32'h0, 1'b1, OP_OR, 32'h1, 32'h2, 1'b1, 1'b0);
    checkOutput("bp_exit_req1", 32'(req1_ready), 32'h0);
    advance();
    applyStimulus(1'b0, OP_NOP, 32'h0, 32'h0, 1'b1, OP_OR, 32'h1, 32'h2, 1'b0, 1'b1);
    checkOutput("bp_req1_ready", 32'(req1_ready), 32'h1);
    advance();
    repeat (3) begin applyIdle(1'b1, 1'b1); advance(); end

    // reset during EXEC discards the operation
    applyStimulus(1'b1, OP_SHRL, 32'hf0f0f0f0, 32'h4, 1'b0, OP_NOP, 32'h0, 32'h0, 1'b1, 1'b0);
    advance();
    applyIdle(1'b1, 1'b0);
    checkOutput("rx_alu_op", 32'(alu_op), 32'(OP_SHRL));
    doReset();
    repeat (4) begin applyIdle(1'b1, 1'b1); advance(); end
    applyStimulus(1'b1, OP_SHRL, 32'hf0f0f0f0, 32'h4, 1'b0, OP_NOP, 32'h0, 32'h0, 1'b1, 1'b0);
    advance();
    applyIdle(1'b1, 1'b0);
    advance();
    applyIdle(1'b1, 1'b0);
    checkOutput("rx_rsp0_out", rsp0_out, 32'h0f0f0f0f);
    advance();

    // idle ALU drive
    for (int i = 0; i < 10; i++) begin
      applyIdle(1'b0, 1'b0);
      checkOutput("idle_alu_op", 32'(alu_op), 32'(OP_NOP));
      checkOutput("idle_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'h0);
      advance();
    end

    // randomized traffic: requesters hold valid until accepted, may withdraw
    p0v = 1'b0; p1v = 1'b0;
    p0o = OP_NOP; p1o = OP_NOP;
    p0a = '0; p0b = '0; p1a = '0; p1b = '0;
    for (int c = 0; c < 400; c++) begin
      if (!p0v) begin
        if ($urandom_range(1, 0) == 1) begin
          p0v = 1'b1; p0o = 4'($urandom_range(9, 1)); p0a = $urandom; p0b = $urandom;
        end
      end else if ($urandom_range(7, 0) == 0) begin
        p0v = 1'b0;
      end
      if (!p1v) begin
        if ($urandom_range(1, 0) == 1) begin
          p1v = 1'b1; p1o = 4'($urandom_range(9, 1)); p1a = $urandom; p1b = $urandom;
        end
      end else if ($urandom_range(7, 0) == 0) begin
        p1v = 1'b0;
      end
      applyStimulus(p0v, p0o, p0a, p0b, p1v, p1o, p1a, p1b,
                    1'($urandom_range(3, 0) != 0), 1'($urandom_range(3, 0) != 0));
      advance();
      if (acc0) p0v = 1'b0;
      if (acc1) p1v = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
